// File: rtl/rf_stream_reader_if.sv
// rf_stream_reader_if: command, rf8 read port and output stream bundle (master = reader, slave = environment)
interface rf_stream_reader_if #(parameter int AW = 3, parameter int DW = 8);
  logic start;
  logic [AW-1:0] base_addr;
  logic [AW:0] len;
  logic abort;
  logic [AW-1:0] rf_ra;
  logic [DW-1:0] rf_dout;
  logic [DW-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic busy;
  logic done;
  modport master(
    input start, base_addr, len, abort, rf_dout, out_ready,
    output rf_ra, out_data, out_valid, out_last, busy, done
  );
  modport slave(
    output start, base_addr, len, abort, rf_dout, out_ready,
    input rf_ra, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/rf_stream_reader.sv
// rf_stream_reader: walks rf8 read address over a wrapping range and streams each word out with last/done framing
module rf_stream_reader #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input logic clk,
  input logic rst,
  rf_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
  state_t st, st_n;
  logic [AW-1:0] addr, addr_n;
  logic [AW:0] rem, rem_n;
  logic [DW-1:0] data, data_n;
  logic valid, valid_n, last, last_n, done, done_n;
  logic hs, kill;
  assign hs = valid && bus.out_ready;
  assign kill = bus.abort && st != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      addr <= '0;
      rem <= '0;
      data <= '0;
      valid <= 1'b0;
      last <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= st_n;
      addr <= addr_n;
      rem <= rem_n;
      data <= data_n;
      valid <= valid_n;
      last <= last_n;
      done <= done_n;
    end
  end
  always_comb begin
    st_n = st;
    addr_n = addr;
    rem_n = rem;
    data_n = data;
    valid_n = valid;
    last_n = last;
    done_n = 1'b0;
    case (st)
      IDLE: begin
        if (bus.start && bus.len != '0) begin
          addr_n = bus.base_addr;
          rem_n = bus.len;
          st_n = FETCH;
        end
        done_n = bus.start && bus.len == '0;
      end
      FETCH: begin
        data_n = bus.rf_dout;
        valid_n = 1'b1;
        last_n = rem == (AW+1)'(1);
        st_n = SEND;
      end
      SEND: begin
        if (hs) begin
          valid_n = 1'b0;
          last_n = 1'b0;
          done_n = rem == (AW+1)'(1);
          st_n = rem == (AW+1)'(1) ? IDLE : FETCH;
          addr_n = rem == (AW+1)'(1) ? addr : addr + AW'(1);
          rem_n = rem == (AW+1)'(1) ? rem : rem - (AW+1)'(1);
        end
      end
      default: st_n = IDLE;
    endcase
    if (kill) begin
      st_n = IDLE;
      addr_n = addr;
      rem_n = rem;
      valid_n = 1'b0;
      last_n = 1'b0;
      done_n = 1'b0;
    end
  end
  assign bus.rf_ra = addr;
  assign bus.out_data = data;
  assign bus.out_valid = valid;
  assign bus.out_last = last;
  assign bus.busy = st != IDLE;
  assign bus.done = done;
endmodule

// File: tb/tb_rf_stream_reader.sv
// tb_rf_stream_reader: randomized scoreboard bench with an rf8 array model and directed boundary cases
module tb_rf_stream_reader;
  logic clk = 0;
  logic rst = 1;
  logic [7:0] mem [8];
  logic ready_fixed = 0, ready_rnd = 0, rnd = 0;
  logic [8:0] sbq [$];
  int hs_cyc [$];
  int ra_log [$];
  int cyc = 0, checks = 0, passes = 0, done_cnt = 0, exp_done = 0, done_cyc = 0, hs_cnt = 0;
  rf_stream_reader_if #(.AW(3), .DW(8)) bus();
  rf_stream_reader #(.AW(3), .DW(8)) dut(.clk(clk), .rst(rst), .bus(bus.master));
  assign bus.rf_dout = mem[bus.rf_ra];
  assign bus.out_ready = rnd ? ready_rnd : ready_fixed;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 ready_rnd = 1'($urandom_range(0, 1));
  end
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s got=%0d exp=%0d", n, got, exp);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy && !bus.out_valid) ra_log.push_back(int'(bus.rf_ra));
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        chk("beat_expected", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          logic [8:0] e;
          e = sbq.pop_front();
          chk("out_data", int'(bus.out_data), int'(e[7:0]));
          chk("out_last", int'(bus.out_last), int'(e[8]));
        end
        hs_cyc.push_back(cyc);
        hs_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_during_done", int'(bus.busy), 0);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_xfer(input int base, input int len);
    bus.start = 1;
    bus.base_addr = 3'(base);
    bus.len = 4'(len);
    for (int k = 0; k < len; k++)
      sbq.push_back({1'(k == len - 1), mem[(base + k) % 8]});
    exp_done++;
    tick();
    bus.start = 0;
  endtask
  task automatic wait_idle();
    int to = 1;
    for (int i = 0; i < 400; i++) begin
      if (!bus.busy && sbq.size() == 0) begin
        to = 0;
        break;
      end
      tick();
    end
    chk("idle_timeout", to, 0);
  endtask
  task automatic wait_valid();
    int to = 1;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid) begin
        to = 0;
        break;
      end
      tick();
    end
    chk("valid_timeout", to, 0);
  endtask
  initial begin
    int t0;
    bus.start = 0;
    bus.base_addr = 0;
    bus.len = 0;
    bus.abort = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    bus.start = 1;
    bus.abort = 1;
    bus.len = 4;
    repeat (3) tick();
    bus.start = 0;
    bus.abort = 0;
    chk("rst_ra", int'(bus.rf_ra), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_last", int'(bus.out_last), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 0;
    tick();
    ready_fixed = 1;
    hs_cyc.delete();
    start_xfer(0, 8);
    chk("lat_fetch_busy", int'(bus.busy), 1);
    chk("lat_fetch_valid", int'(bus.out_valid), 0);
    tick();
    chk("lat_send_valid", int'(bus.out_valid), 1);
    wait_idle();
    tick();
    chk("basic_beats", hs_cyc.size(), 8);
    if (hs_cyc.size() == 8) begin
      chk("basic_rate", hs_cyc[7] - hs_cyc[0], 14);
      chk("basic_done_lat", done_cyc, hs_cyc[7] + 1);
    end
    chk("basic_busy_after", int'(bus.busy), 0);
    ra_log.delete();
    start_xfer(6, 4);
    wait_idle();
    chk("wrap_ra_n", ra_log.size(), 4);
    if (ra_log.size() == 4) begin
      chk("wrap_ra0", ra_log[0], 6);
      chk("wrap_ra1", ra_log[1], 7);
      chk("wrap_ra2", ra_log[2], 0);
      chk("wrap_ra3", ra_log[3], 1);
    end
    ready_fixed = 0;
    hs_cyc.delete();
    start_xfer(2, 2);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", int'(bus.out_data), 8'hA2);
      chk("bp_valid", int'(bus.out_valid), 1);
      tick();
    end
    ready_fixed = 1;
    wait_idle();
    chk("bp_beats", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) chk("bp_gap", hs_cyc[1] - hs_cyc[0], 2);
    start_xfer(3, 0);
    chk("zl_done", int'(bus.done), 1);
    chk("zl_valid", int'(bus.out_valid), 0);
    chk("zl_busy", int'(bus.busy), 0);
    tick();
    chk("zl_done_pulse", int'(bus.done), 0);
    ready_fixed = 0;
    start_xfer(0, 8);
    wait_valid();
    bus.start = 1;
    bus.base_addr = 5;
    bus.len = 3;
    tick();
    bus.start = 0;
    chk("ign_ra", int'(bus.rf_ra), 0);
    chk("ign_data", int'(bus.out_data), 8'hA0);
    ready_fixed = 1;
    wait_idle();
    t0 = hs_cnt;
    start_xfer(0, 8);
    for (int i = 0; i < 50 && hs_cnt - t0 < 2; i++) tick();
    ready_fixed = 0;
    wait_valid();
    t0 = done_cnt;
    bus.abort = 1;
    tick();
    bus.abort = 0;
    chk("ab_valid", int'(bus.out_valid), 0);
    chk("ab_last", int'(bus.out_last), 0);
    chk("ab_busy", int'(bus.busy), 0);
    chk("ab_ra", int'(bus.rf_ra), 2);
    sbq.delete();
    exp_done--;
    tick();
    chk("ab_no_done", done_cnt, t0);
    ready_fixed = 1;
    bus.abort = 1;
    start_xfer(4, 3);
    bus.abort = 0;
    wait_idle();
    ready_fixed = 0;
    start_xfer(3, 1);
    wait_valid();
    chk("abl_last", int'(bus.out_last), 1);
    t0 = done_cnt;
    ready_fixed = 1;
    bus.abort = 1;
    tick();
    bus.abort = 0;
    chk("abl_done", int'(bus.done), 0);
    chk("abl_busy", int'(bus.busy), 0);
    sbq.delete();
    exp_done--;
    tick();
    chk("abl_no_done", done_cnt, t0);
    start_xfer(5, 4);
    chk("rf_fetch", int'(bus.busy && !bus.out_valid), 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rf_ra", int'(bus.rf_ra), 0);
    chk("rf_data", int'(bus.out_data), 0);
    chk("rf_valid", int'(bus.out_valid), 0);
    chk("rf_busy", int'(bus.busy), 0);
    chk("rf_done", int'(bus.done), 0);
    sbq.delete();
    exp_done--;
    tick();
    rnd = 1;
    start_xfer(0, 10);
    wait_idle();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      start_xfer(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      wait_idle();
    end
    repeat (3) tick();
    chk("sb_empty", sbq.size(), 0);
    chk("done_count", done_cnt, exp_done);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rf_stream_reader.md
Name: rf_stream_reader

Overview:
- Read-side master for the 8-entry register file (rf8).
- On a start command, drives the register-file read address through a contiguous, wrapping range of entries.
- Captures each combinational read result into an output register.
- Streams the captured words out on a valid/ready interface, framed with a last flag and a done pulse.
- Sits between rf8's read port (ra/dout) and any downstream consumer, such as a debug dump or a DMA-style bus.

Parameters:
- AW, 3, register-file address width; depth is 2^AW, and all addresses wrap modulo 2^AW.
- DW, 8, data width; must match rf8 dout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  AW  first entry to read; sampled with start.
- len  input  AW+1  number of words to stream, 0..2^(AW+1)-1; sampled with start.
- abort  input  1  synchronous cancel of the transfer in progress.
- rf_ra  output  AW  read address to rf8; registered.
- rf_dout  input  DW  combinational read data from rf8.
- out_data  output  DW  streamed word; registered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
- out_last  output  1  qualifies the final word of the transfer; meaningful only when out_valid is high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a transfer completes normally.

Behaviour:
- Reset, with rst high at a clock edge:
  - State goes to IDLE.
  - rf_ra=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
  - Internal addr=0 and remaining=0.
  - Reset overrides start and abort in the same cycle.
- rf_ra always equals the internal addr register; it is never driven combinationally from inputs.
- State IDLE:
  - start=1 and len>0: addr<=base_addr, remaining<=len, go to FETCH.
  - start=1 and len=0: no beats are produced; done pulses on the next cycle and the state stays IDLE.
  - start=0: hold.
- State FETCH, exactly one cycle:
  - rf_ra already equals addr, so rf_dout is stable in this cycle.
  - out_data<=rf_dout, out_valid<=1, out_last<=(remaining==1).
  - Go to SEND.
- State SEND:
  - Hold out_data, out_valid and out_last stable until the handshake occurs; backpressure may last indefinitely.
  - On handshake with remaining==1: out_valid<=0, out_last<=0, done<=1 for one cycle, go to IDLE.
  - On handshake with remaining>1: addr<=addr+1 (wrapping from 2^AW-1 to 0), remaining<=remaining-1, out_valid<=0, go to FETCH.
  - No handshake: stay in SEND.
- Throughput: one word per 2 cycles at most, with no bubbles beyond FETCH.
- Latency: start to first out_valid is 2 cycles (start edge into FETCH, FETCH edge into SEND).
- len larger than 2^AW re-reads entries in wrap order. Example: base=6, len=10 reads 6,7,0,1,...,7.
- start while busy is ignored; the command is not queued.
- abort=1 while busy:
  - Next edge: out_valid=0, out_last=0, go to IDLE.
  - done is not pulsed.
  - rf_ra holds its last value.
  - Any word not yet handshaken is discarded.
- abort in IDLE has no effect.
- abort and start in the same IDLE cycle: start is taken and abort is ignored.
- abort coincident with the final handshake: abort wins, and done is not pulsed.
- Register-file writes during a transfer are not blocked. Each word reflects the rf8 contents in its FETCH cycle.
- busy=1 in FETCH and SEND. busy is low in the cycle done is high.

Test Plan:
- Basic dump:
  - Stimulus: preload rf8 with r[i]=8'hA0+i, start with base=0, len=8, out_ready held at 1.
  - Required: 8 beats A0..A7 on out_valid, one every 2 cycles; out_last only on A7; done one cycle after the A7 handshake; busy low afterwards.
- Wrap:
  - Stimulus: base=6, len=4.
  - Required: rf_ra sequence 6,7,0,1; data A6,A7,A0,A1; out_last on A1.
- Backpressure:
  - Stimulus: base=2, len=2, out_ready low for 5 cycles after the first out_valid.
  - Required: out_data=A2 held stable and out_valid held high through the stall; A3 follows 2 cycles after the handshake; no beat is lost or duplicated.
- Zero length and ignored start:
  - Stimulus: start with len=0.
  - Required: no out_valid; done pulses one cycle later.
  - Stimulus: a second start mid-transfer with base=5.
  - Required: no change to rf_ra or remaining.
- Abort and reset mid-transfer:
  - Stimulus: abort during SEND of beat 3 of len=8.
  - Required: out_valid drops next cycle, no done, state IDLE; a new start then works normally.
  - Stimulus: rst asserted during FETCH.
  - Required: all outputs at their reset values at the next edge.
- Overlong length:
  - Stimulus: base=0, len=10.
  - Required: data A0..A7,A0,A1; out_last on the second A1; done pulses once.
